// File: rtl/dfu_boot_helper_pkg.sv
// Shared constants for the DFU boot helper: button pad modes, warm-boot
// image numbers and the image a long press selects.
package dfu_boot_helper_pkg;

  localparam int unsigned SEL_W = 2;

  localparam int unsigned BTN_NONE       = 0;
  localparam int unsigned BTN_ACT_HIGH   = 1;
  localparam int unsigned BTN_ACT_LOW    = 2;
  localparam int unsigned BTN_ACT_LOW_PU = 3;

  localparam logic [SEL_W-1:0] IMG_GOLDEN = SEL_W'(0);
  localparam logic [SEL_W-1:0] IMG_DFU    = SEL_W'(1);
  localparam logic [SEL_W-1:0] IMG_APP    = SEL_W'(2);

  localparam int unsigned DFU_MODE_APP = 0;
  localparam int unsigned DFU_MODE_DFU = 1;

  // A long press always jumps to the "other" image.
  function automatic logic [SEL_W-1:0] long_img(input int unsigned dfu_mode);
    return (dfu_mode == DFU_MODE_DFU) ? IMG_APP : IMG_DFU;
  endfunction

endpackage

// File: rtl/dfu_boot_helper_if.sv
// Button / warm-boot signal bundle between the SoC side (master) and the
// boot helper (slave).
interface dfu_boot_helper_if;
  import dfu_boot_helper_pkg::*;

  logic             boot_now;
  logic [SEL_W-1:0] boot_sel;
  logic             btn_pad;
  logic             btn_val;
  logic             rst_req;
  logic             warm_boot;
  logic [SEL_W-1:0] warm_sel;

  modport master (
    output boot_now, boot_sel, btn_pad,
    input  btn_val, rst_req, warm_boot, warm_sel
  );

  modport slave (
    input  boot_now, boot_sel, btn_pad,
    output btn_val, rst_req, warm_boot, warm_sel
  );

endinterface

// File: rtl/btn_debounce.sv
// Two-flop pad synchronizer followed by a debounce counter: the level only
// flips after D consecutive cycles of disagreement with the current level.
module btn_debounce #(
  parameter int unsigned D      = 4,
  parameter bit          INVERT = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic i_pad,
  output logic o_val
);

  localparam int unsigned CNT_W = (D > 1) ? $clog2(D) : 1;

  logic             r_s1;
  logic             r_s2;
  logic             r_val;
  logic [CNT_W-1:0] r_cnt;
  logic             w_differ;

  assign w_differ = (r_s2 != r_val);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1  <= 1'b0;
      r_s2  <= 1'b0;
      r_val <= 1'b0;
      r_cnt <= '0;
    end else begin
      r_s1 <= i_pad ^ INVERT;
      r_s2 <= r_s1;
      if (!w_differ) begin
        r_cnt <= '0;
      end else if (r_cnt == CNT_W'(D - 1)) begin
        r_cnt <= '0;
        r_val <= ~r_val;
      end else begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

  assign o_val = r_val;

endmodule

// File: rtl/dfu_boot_helper.sv
// Boot/reset helper: debounced button, short press -> rst_req pulse, long press
// or software request -> sticky warm boot. DFU_HELPER_WARMBOOT_EN adds iCE40 primitives.
module dfu_boot_helper
  import dfu_boot_helper_pkg::*;
#(
  parameter int unsigned TIMER_WIDTH = 24,
  parameter int unsigned BTN_MODE    = 3,
  parameter int unsigned DFU_MODE    = 0
) (
  input logic              clk,
  input logic              rst,
  dfu_boot_helper_if.slave bus
);

  localparam int unsigned            DEB_LEN   = 1 << (TIMER_WIDTH - 8);
  localparam logic [TIMER_WIDTH-1:0] TIMER_MAX = '1;
  localparam logic [SEL_W-1:0]       LONG_IMG  = long_img(DFU_MODE);
  localparam bit                     BTN_EN    = (BTN_MODE != BTN_NONE);

  logic                   w_pad;
  logic                   w_deb_val;
  logic                   w_btn_val;
  logic                   w_sat;
  logic                   w_long;
  logic                   w_fall;
  logic [TIMER_WIDTH-1:0] r_timer;
  logic                   r_sat_d;
  logic                   r_btn_d;
  logic                   r_rst_req;
  logic                   r_warm_boot;
  logic [SEL_W-1:0]       r_warm_sel;

`ifdef DFU_HELPER_WARMBOOT_EN
  generate
    if (BTN_MODE == BTN_ACT_LOW_PU) begin : g_pad_pu
      SB_IO #(.PIN_TYPE(6'b000001), .PULLUP(1'b1)) u_pad_io (
        .PACKAGE_PIN (bus.btn_pad),
        .D_IN_0      (w_pad)
      );
    end else begin : g_pad_plain
      assign w_pad = bus.btn_pad;
    end
  endgenerate
`else
  assign w_pad = bus.btn_pad;
`endif

  btn_debounce #(
    .D      (DEB_LEN),
    .INVERT (BTN_MODE >= BTN_ACT_LOW)
  ) u_debounce (
    .clk   (clk),
    .rst   (rst),
    .i_pad (w_pad),
    .o_val (w_deb_val)
  );

  // With no button fitted the whole press path folds away to constants.
  assign w_btn_val = BTN_EN & w_deb_val;
  assign w_sat     = (r_timer == TIMER_MAX);
  assign w_long    = w_sat & ~r_sat_d;
  assign w_fall    = r_btn_d & ~w_btn_val;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_timer     <= '0;
      r_sat_d     <= 1'b0;
      r_btn_d     <= 1'b0;
      r_rst_req   <= 1'b0;
      r_warm_boot <= 1'b0;
      r_warm_sel  <= '0;
    end else begin
      if (!w_btn_val) begin
        r_timer <= '0;
      end else if (!w_sat) begin
        r_timer <= r_timer + TIMER_WIDTH'(1);
      end
      r_sat_d   <= w_sat;
      r_btn_d   <= w_btn_val;
      r_rst_req <= w_fall & ~w_sat;
      // Software request wins over a simultaneous long press; latch is sticky.
      if (!r_warm_boot) begin
        if (bus.boot_now) begin
          r_warm_boot <= 1'b1;
          r_warm_sel  <= bus.boot_sel;
        end else if (w_long) begin
          r_warm_boot <= 1'b1;
          r_warm_sel  <= LONG_IMG;
        end
      end
    end
  end

`ifdef DFU_HELPER_WARMBOOT_EN
  SB_WARMBOOT u_warmboot (
    .BOOT (r_warm_boot),
    .S1   (r_warm_sel[1]),
    .S0   (r_warm_sel[0])
  );
`endif

  assign bus.btn_val   = w_btn_val;
  assign bus.rst_req   = r_rst_req;
  assign bus.warm_boot = r_warm_boot;
  assign bus.warm_sel  = r_warm_sel;

endmodule

// File: tb/tb_dfu_boot_helper.sv
// Randomized bench for dfu_boot_helper: three configurations run side by side
// against a cycle-level behavioural model built from run lengths and histories.
module tb_dfu_boot_helper;

  localparam int unsigned TW   = 10;
  localparam int unsigned D    = 1 << (TW - 8);
  localparam int unsigned MAXT = (1 << TW) - 1;
  localparam int unsigned MODE [3] = '{1, 2, 0};
  localparam int unsigned DFUM [3] = '{0, 1, 0};

  logic       clk;
  logic       rst;
  logic       pad [3];
  logic       bn  [3];
  logic [1:0] bs  [3];

  int n_chk;
  int n_err;

  // reference model state
  bit         m_h1 [3];
  bit         m_h2 [3];
  int         m_run [3];
  int         m_ones [3];
  bit         m_bv [3];
  bit         m_bvp [3];
  bit         m_rr [3];
  bit         m_wb [3];
  logic [1:0] m_ws [3];

  dfu_boot_helper_if bus0 ();
  dfu_boot_helper_if bus1 ();
  dfu_boot_helper_if bus2 ();

  assign bus0.btn_pad = pad[0];
  assign bus0.boot_now = bn[0];
  assign bus0.boot_sel = bs[0];
  assign bus1.btn_pad = pad[1];
  assign bus1.boot_now = bn[1];
  assign bus1.boot_sel = bs[1];
  assign bus2.btn_pad = pad[2];
  assign bus2.boot_now = bn[2];
  assign bus2.boot_sel = bs[2];

  dfu_boot_helper #(.TIMER_WIDTH(TW), .BTN_MODE(1), .DFU_MODE(0)) u_dut0 (
    .clk (clk), .rst (rst), .bus (bus0.slave));
  dfu_boot_helper #(.TIMER_WIDTH(TW), .BTN_MODE(2), .DFU_MODE(1)) u_dut1 (
    .clk (clk), .rst (rst), .bus (bus1.slave));
  dfu_boot_helper #(.TIMER_WIDTH(TW), .BTN_MODE(0), .DFU_MODE(0)) u_dut2 (
    .clk (clk), .rst (rst), .bus (bus2.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic logic [4:0] dut_out(input int k);
    case (k)
      0:       return {bus0.btn_val, bus0.rst_req, bus0.warm_boot, bus0.warm_sel};
      1:       return {bus1.btn_val, bus1.rst_req, bus1.warm_boot, bus1.warm_sel};
      default: return {bus2.btn_val, bus2.rst_req, bus2.warm_boot, bus2.warm_sel};
    endcase
  endfunction

  // One clock edge of the expected behaviour, using inputs held over the edge.
  task automatic model_step(input int k);
    bit raw;
    bit synced;
    bit long_ev;
    raw = (MODE[k] == 0) ? 1'b0 : ((MODE[k] == 1) ? pad[k] : !pad[k]);
    if (rst) begin
      m_h1[k] = 0; m_h2[k] = 0; m_run[k] = 0; m_ones[k] = 0;
      m_bv[k] = 0; m_bvp[k] = 0; m_rr[k] = 0; m_wb[k] = 0; m_ws[k] = 2'b00;
    end else begin
      // ones = cycles the debounced level has been high just before now
      long_ev = (m_ones[k] == int'(MAXT));
      m_rr[k] = !m_bv[k] && m_bvp[k] && (m_ones[k] < int'(MAXT));
      if (!m_wb[k]) begin
        if (bn[k]) begin
          m_wb[k] = 1; m_ws[k] = bs[k];
        end else if (long_ev) begin
          m_wb[k] = 1; m_ws[k] = (DFUM[k] == 1) ? 2'b10 : 2'b01;
        end
      end
      m_ones[k] = m_bv[k] ? m_ones[k] + 1 : 0;
      m_bvp[k]  = m_bv[k];
      synced  = m_h2[k];
      m_h2[k] = m_h1[k];
      m_h1[k] = raw;
      if (synced == m_bv[k]) m_run[k] = 0;
      else if (m_run[k] == int'(D) - 1) begin
        m_bv[k] = !m_bv[k]; m_run[k] = 0;
      end else m_run[k]++;
    end
  endtask

  task automatic cyc();
    logic [4:0] o;
    @(posedge clk);
    for (int k = 0; k < 3; k++) model_step(k);
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      o = dut_out(k);
      check_val($sformatf("btn_val%0d", k),   32'(o[4]),   32'(m_bv[k]));
      check_val($sformatf("rst_req%0d", k),   32'(o[3]),   32'(m_rr[k]));
      check_val($sformatf("warm_boot%0d", k), 32'(o[2]),   32'(m_wb[k]));
      check_val($sformatf("warm_sel%0d", k),  32'(o[1:0]), 32'(m_ws[k]));
    end
  endtask

  task automatic press(input int k, input bit v);
    pad[k] = (MODE[k] == 2) ? !v : v;
  endtask

  task automatic idle_all();
    for (int k = 0; k < 3; k++) begin
      press(k, 1'b0); bn[k] = 1'b0; bs[k] = 2'b00;
    end
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    repeat (n) cyc();
    rst = 1'b0;
  endtask

  int         cnt;
  int         cnt_bv;
  logic [4:0] o0;

  initial begin
    n_chk = 0;
    n_err = 0;
    rst   = 1'b1;
    idle_all();
    do_reset(3);
    cyc();
    o0 = dut_out(0);
    check_val("reset_outs0", 32'(o0), 32'(0));

    // Short press then release
    press(0, 1); press(1, 1);
    cnt = 0;
    for (int i = 0; i < 40; i++) begin
      pad[2] = 1'(i % 2);
      cyc();
      if (bus0.rst_req) cnt++;
    end
    check_val("short_btn_high0", 32'(bus0.btn_val), 32'(1));
    press(0, 0); press(1, 0);
    for (int i = 0; i < 30; i++) begin
      cyc();
      if (bus0.rst_req) cnt++;
    end
    check_val("short_pulses0", 32'(cnt), 32'(1));
    check_val("short_wb0", 32'(bus0.warm_boot), 32'(0));

    // Glitch train shorter than the debounce length
    cnt = 0; cnt_bv = 0;
    for (int i = 0; i < 60; i++) begin
      press(0, (i % 6) < 3); press(1, (i % 6) < 3); pad[2] = (i % 6) < 3;
      cyc();
      if (bus0.rst_req) cnt++;
      if (bus0.btn_val) cnt_bv++;
    end
    check_val("glitch_btn0", 32'(cnt_bv), 32'(0));
    check_val("glitch_rr0", 32'(cnt), 32'(0));

    // Random pad bouncing
    idle_all();
    for (int i = 0; i < 400; i++) begin
      for (int k = 0; k < 3; k++)
        if ($urandom_range(5) == 0) pad[k] = !pad[k];
      cyc();
    end
    idle_all();
    repeat (20) cyc();
    do_reset(2);

    // Long press on both; dut1 gets a software request on the saturation cycle
    press(0, 1); press(1, 1);
    for (int i = 0; i < 1100; i++) begin
      bn[1] = (m_ones[1] == int'(MAXT)); bs[1] = 2'b11;
      cyc();
    end
    bn[1] = 1'b0;
    check_val("long_wb0", 32'(bus0.warm_boot), 32'(1));
    check_val("long_sel0", 32'(bus0.warm_sel), 32'(2'b01));
    check_val("sat_sw_sel1", 32'(bus1.warm_sel), 32'(2'b11));
    press(0, 0); press(1, 0);
    cnt = 0;
    for (int i = 0; i < 30; i++) begin
      cyc();
      if (bus0.rst_req) cnt++;
    end
    check_val("long_no_rr0", 32'(cnt), 32'(0));
    do_reset(2);

    // Software boot on dut0/dut2, long press alone on dut1
    press(1, 1);
    for (int i = 0; i < 1100; i++) begin
      bn[0] = (i == 5 || i == 20); bs[0] = (i == 20) ? 2'b11 : 2'b10;
      bn[2] = (i == 50); bs[2] = 2'b01;
      pad[2] = 1'($urandom_range(1));
      cyc();
      if (i == 5) begin
        check_val("sw_wb0", 32'(bus0.warm_boot), 32'(1));
        check_val("sw_sel0", 32'(bus0.warm_sel), 32'(2'b10));
      end
    end
    check_val("sw_frozen_sel0", 32'(bus0.warm_sel), 32'(2'b10));
    check_val("long_sel1", 32'(bus1.warm_sel), 32'(2'b10));
    check_val("nobtn_sw_sel2", 32'(bus2.warm_sel), 32'(2'b01));
    idle_all();
    do_reset(2);

    // Reset in the middle of a hold, pad released with the reset
    press(0, 1);
    repeat (100) cyc();
    check_val("hold_btn0", 32'(bus0.btn_val), 32'(1));
    rst = 1'b1; press(0, 0);
    cyc();
    rst = 1'b0;
    o0 = dut_out(0);
    check_val("midrst_outs0", 32'(o0), 32'(0));
    cnt = 0;
    for (int i = 0; i < 30; i++) begin
      cyc();
      if (bus0.rst_req) cnt++;
    end
    check_val("midrst_no_rr0", 32'(cnt), 32'(0));

    // Random bouncing with sporadic software requests
    for (int i = 0; i < 300; i++) begin
      for (int k = 0; k < 3; k++) begin
        if ($urandom_range(7) == 0) pad[k] = !pad[k];
        bn[k] = ($urandom_range(149) == 0);
        bs[k] = 2'($urandom_range(3));
      end
      cyc();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
